// File: rtl/tx_byte_ctrl.sv
// tx_byte_ctrl: serial slave transmit byte sequencer that pops the FIFO, gates MSB-first shifting
// to SCL falling edges, samples the master ACK/NACK and chains bytes until NACK, STOP or underrun.
module tx_byte_ctrl (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_start,
    input  logic start_found,
    input  logic stop_found,
    input  logic rising_edge_found,
    input  logic falling_edge_found,
    input  logic sda_in,
    input  logic fifo_empty,
    output logic fifo_pop,
    output logic load_data,
    output logic tx_enable,
    output logic sda_drive,
    output logic byte_done,
    output logic nack,
    output logic underrun,
    output logic abort
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, ACK_WAIT, ACK_HOLD} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic byte_done_nxt, nack_nxt, underrun_nxt, abort_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_done <= 1'b0;
            nack      <= 1'b0;
            underrun  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            byte_done <= byte_done_nxt;
            nack      <= nack_nxt;
            underrun  <= underrun_nxt;
            abort     <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        byte_done_nxt = 1'b0;
        nack_nxt      = 1'b0;
        underrun_nxt  = 1'b0;
        abort_nxt     = 1'b0;
        case (state)
            IDLE: if (tx_start) begin
                underrun_nxt = fifo_empty;
                state_nxt    = fifo_empty ? IDLE : LOAD;
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = SEND;
            end
            // cnt[3] is the terminal flag: set by the 8th falling edge
            SEND: if (falling_edge_found) begin
                cnt_nxt   = cnt + 4'd1;
                state_nxt = cnt_nxt[3] ? ACK_WAIT : SEND;
            end
            ACK_WAIT: if (rising_edge_found) begin
                byte_done_nxt = 1'b1;
                nack_nxt      = sda_in;
                state_nxt     = sda_in ? IDLE : ACK_HOLD;
            end
            ACK_HOLD: if (falling_edge_found) begin
                underrun_nxt = fifo_empty;
                state_nxt    = fifo_empty ? IDLE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && (start_found || stop_found)) begin
            state_nxt     = IDLE;
            byte_done_nxt = 1'b0;
            nack_nxt      = 1'b0;
            underrun_nxt  = 1'b0;
            abort_nxt     = 1'b1;
        end
    end

    assign load_data = state == LOAD;
    assign fifo_pop  = state == LOAD;
    assign tx_enable = state == SEND;
    assign sda_drive = state == SEND;
endmodule

// File: doc/tx_byte_ctrl.md
# tx_byte_ctrl

Byte-level transmit sequencer for the serial slave transmit path. It pops bytes from the transmit FIFO, loads them into the 8-bit MSB-first transmit shift register, and gates shifting to detected SCL falling edges. It also releases the data line for the acknowledge bit, samples the master's ACK/NACK, and chains consecutive bytes until NACK, STOP, or FIFO underrun. It sits between the bus edge/condition detectors and the transmit shift register plus FIFO.

## Interface
- No parameters. Byte width is fixed at 8 bits.
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- tx_start  input  1  one-cycle pulse: addressed read transaction begins (SCL low after address ACK)
- start_found  input  1  one-cycle pulse: bus START/repeated START detected
- stop_found  input  1  one-cycle pulse: bus STOP detected
- rising_edge_found  input  1  one-cycle pulse: SCL rising edge
- falling_edge_found  input  1  one-cycle pulse: SCL falling edge
- sda_in  input  1  synchronized SDA level
- fifo_empty  input  1  transmit FIFO empty
- fifo_pop  output  1  one-cycle read strobe to transmit FIFO
- load_data  output  1  parallel-load strobe to transmit shift register
- tx_enable  output  1  shift enable qualifier (shift register shifts on falling_edge_found & tx_enable)
- sda_drive  output  1  1 = drive SDA from shift register output, 0 = release
- byte_done  output  1  one-cycle pulse when ACK/NACK sampled
- nack  output  1  one-cycle pulse coincident with byte_done when master sent NACK
- underrun  output  1  one-cycle pulse when a byte is needed and FIFO is empty
- abort  output  1  one-cycle pulse when START/STOP ends a transfer mid-byte or mid-ACK

## Operation
- States: IDLE, LOAD, SEND, ACK_WAIT, ACK_HOLD.
- IDLE: all outputs 0. On tx_start with fifo_empty=0, go to LOAD. On tx_start with fifo_empty=1, pulse underrun and stay in IDLE.
- LOAD: exactly one cycle. load_data=1 and fifo_pop=1 together. Clear bit counter (3-bit plus terminal flag). Go to SEND.
- SEND: tx_enable=1, sda_drive=1. Each falling_edge_found increments the bit counter. On the 8th falling edge, go to ACK_WAIT. The 8th shift is harmless because the register is reloaded before its next use.
- ACK_WAIT: tx_enable=0, sda_drive=0. On rising_edge_found, sample sda_in and pulse byte_done.
  - sda_in=0 (ACK): go to ACK_HOLD.
  - sda_in=1 (NACK): pulse nack and go to IDLE.
- ACK_HOLD: sda_drive=0. On falling_edge_found:
  - fifo_empty=0: go to LOAD.
  - fifo_empty=1: pulse underrun and go to IDLE.
- Abort: start_found or stop_found in any state other than IDLE sends the state to IDLE in the next cycle and pulses abort. This takes priority over any edge in the same cycle. In IDLE these inputs are ignored, with no abort pulse.
- tx_start outside IDLE is ignored.
- fifo_pop is never asserted when fifo_empty=1.

## Timing
- Reset: state=IDLE, bit counter=0, all outputs 0, asynchronously on n_rst=0.
- All outputs are Moore-registered or decoded from the registered state. Pulses (byte_done, nack, underrun, abort) are registered and appear in the cycle after the causing input.
- tx_start is sampled at cycle N. LOAD is active (load_data=fifo_pop=1) at N+1. SEND begins at N+2, with bit 7 on the line.
- Next byte: the falling edge in ACK_HOLD at cycle M gives LOAD at M+1 and SEND at M+2. This must complete before the next SCL rising edge; the bus clock is at least 4 system clocks per half-period.
- Each edge pulse is counted once. Back-to-back falling_edge_found pulses in consecutive cycles each count.
- Reset mid-byte: outputs are immediately 0 and the FIFO is not popped again.

## Test plan
- Single byte with NACK: FIFO holds 0xA5, tx_start pulse, 8 falling edges, then a rising edge with sda_in=1. Expect one load_data/fifo_pop at tx_start+1, tx_enable high for exactly 8 falling edges, sda_drive=0 after the 8th, byte_done and nack pulses, return to IDLE.
- Two bytes with ACK: FIFO holds 0x3C, 0xC3, master ACKs both. Expect 2 loads, 16 counted falling edges, 2 byte_done pulses, no nack, then IDLE after the second ACK when the FIFO is empty, with an underrun pulse.
- Underrun at start: fifo_empty=1 and tx_start. Expect an underrun pulse, no fifo_pop or load_data, state stays IDLE.
- STOP after 4 bits: stop_found after 4 falling edges. Expect an abort pulse, tx_enable and sda_drive 0 the next cycle, no byte_done.
- Simultaneous falling_edge_found and start_found on the 8th edge: abort wins and there is no ACK_WAIT. Afterwards, tx_start in IDLE restarts cleanly.
- Async reset asserted during ACK_WAIT: all outputs 0 immediately. After release, a fresh tx_start completes a byte normally.
